// File: rtl/cache_fill_responder_if.sv
// Cache-side request/burst signals and backing-memory command signals for
// cache_fill_responder. The master side is the cache plus memory (stimulus),
// the slave side is the responder itself.
interface cache_fill_responder_if #(
    parameter int MEMADDRBITS = 24
);
    // cache request side
    logic [31:0]            sdram_addr;
    logic                   sdram_req;
    logic                   sdram_rw;
    logic [15:0]            data_to_sdram;
    logic [1:0]             sdram_wr_be;
    logic [15:0]            data_from_sdram;
    logic                   sdram_fill;
    logic                   sdram_wr_ack;
    // backing memory side
    logic [MEMADDRBITS-1:0] mem_addr;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [1:0]             mem_be;
    logic [15:0]            mem_wdata;
    logic [15:0]            mem_rdata;
    logic                   mem_wait;

    modport master (
        output sdram_addr, sdram_req, sdram_rw, data_to_sdram, sdram_wr_be,
        output mem_rdata, mem_wait,
        input  data_from_sdram, sdram_fill, sdram_wr_ack,
        input  mem_addr, mem_rd, mem_wr, mem_be, mem_wdata
    );

    modport slave (
        input  sdram_addr, sdram_req, sdram_rw, data_to_sdram, sdram_wr_be,
        input  mem_rdata, mem_wait,
        output data_from_sdram, sdram_fill, sdram_wr_ack,
        output mem_addr, mem_rd, mem_wr, mem_be, mem_wdata
    );
endinterface

// File: rtl/cache_fill_responder.sv
// Cache line fill / word write responder. A read request fetches the 8-word
// line starting at the requested word (wrapping inside the line) into a local
// buffer, then streams it to the cache in slot order as one contiguous burst.
// A write request issues one masked word write and acknowledges it.
// Every output is a register; the memory command holds while mem_wait=1.
module cache_fill_responder #(
    parameter int MEMADDRBITS = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_fill_responder_if.slave bus
);

    localparam int MA = MEMADDRBITS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        STREAM  = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t         state, state_n;

    // registered outputs and their next values
    logic [15:0]    dout_q,  dout_n;
    logic           fill_q,  fill_n;
    logic           ack_q,   ack_n;
    logic [MA-1:0]  maddr_q, maddr_n;
    logic           mrd_q,   mrd_n;
    logic           mwr_q,   mwr_n;
    logic [1:0]     mbe_q,   mbe_n;
    logic [15:0]    mwd_q,   mwd_n;

    // burst bookkeeping
    logic [2:0]     start_q, start_n;   // requested start word within the line
    logic [2:0]     iss_k,   iss_n;     // index of the read currently presented
    logic [2:0]     cap_k,   cap_n;     // slot the next returning word lands in
    logic           rd_pend, pend_n;    // a read was accepted last edge; data is on mem_rdata
    logic [2:0]     out_k,   out_n;     // next slot to stream

    logic [15:0]    lbuf [8];
    logic [2:0]     nxt_off;

    // Address bits outside the word-address window are intentionally ignored.
    logic           unused_addr_bits;
    assign unused_addr_bits = ^{bus.sdram_addr[31:MA+1], bus.sdram_addr[0]};

    // Line offset of the read after the one being accepted; 3-bit wrap keeps it inside the line.
    assign nxt_off = start_q + iss_k + 3'd1;

    assign bus.data_from_sdram = dout_q;
    assign bus.sdram_fill      = fill_q;
    assign bus.sdram_wr_ack    = ack_q;
    assign bus.mem_addr        = maddr_q;
    assign bus.mem_rd          = mrd_q;
    assign bus.mem_wr          = mwr_q;
    assign bus.mem_be          = mbe_q;
    assign bus.mem_wdata       = mwd_q;

    // State and output registers; reset forces IDLE and clears every output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dout_q  <= '0;
            fill_q  <= 1'b0;
            ack_q   <= 1'b0;
            maddr_q <= '0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            mbe_q   <= '0;
            mwd_q   <= '0;
            start_q <= '0;
            iss_k   <= '0;
            cap_k   <= '0;
            rd_pend <= 1'b0;
            out_k   <= '0;
        end else begin
            state   <= state_n;
            dout_q  <= dout_n;
            fill_q  <= fill_n;
            ack_q   <= ack_n;
            maddr_q <= maddr_n;
            mrd_q   <= mrd_n;
            mwr_q   <= mwr_n;
            mbe_q   <= mbe_n;
            mwd_q   <= mwd_n;
            start_q <= start_n;
            iss_k   <= iss_n;
            cap_k   <= cap_n;
            rd_pend <= pend_n;
            out_k   <= out_n;
        end
    end

    // Line buffer: each returning read word goes to the slot of its issue order.
    always_ff @(posedge clk) begin
        if (state == FETCH && rd_pend) begin
            lbuf[cap_k] <= bus.mem_rdata;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n = state;
        dout_n  = dout_q;
        fill_n  = 1'b0;
        ack_n   = 1'b0;
        maddr_n = maddr_q;
        mrd_n   = mrd_q;
        mwr_n   = mwr_q;
        mbe_n   = mbe_q;
        mwd_n   = mwd_q;
        start_n = start_q;
        iss_n   = iss_k;
        cap_n   = cap_k;
        pend_n  = rd_pend;
        out_n   = out_k;

        case (state)
            IDLE: begin
                if (bus.sdram_req) begin
                    // Everything the transaction needs is captured here;
                    // later changes on the request inputs are ignored.
                    maddr_n = bus.sdram_addr[MA:1];
                    start_n = bus.sdram_addr[3:1];
                    iss_n   = 3'd0;
                    cap_n   = 3'd0;
                    pend_n  = 1'b0;
                    if (bus.sdram_rw) begin
                        mrd_n   = 1'b1;
                        state_n = FETCH;
                    end else begin
                        mbe_n   = bus.sdram_wr_be;
                        mwd_n   = bus.data_to_sdram;
                        // An all-zero mask writes nothing, so no command is issued.
                        mwr_n   = |bus.sdram_wr_be;
                        state_n = WRITE;
                    end
                end
            end

            FETCH: begin
                pend_n = mrd_q && !bus.mem_wait;
                if (mrd_q && !bus.mem_wait) begin
                    if (iss_k == 3'd7) begin
                        mrd_n = 1'b0;
                    end else begin
                        iss_n   = iss_k + 3'd1;
                        maddr_n = {maddr_q[MA-1:3], nxt_off};
                    end
                end
                if (rd_pend) begin
                    cap_n = cap_k + 3'd1;
                    // Slot 7 is landing now, so slot 0 can start the burst on the same edge.
                    if (cap_k == 3'd7) begin
                        state_n = STREAM;
                        fill_n  = 1'b1;
                        dout_n  = lbuf[0];
                        out_n   = 3'd1;
                    end
                end
            end

            STREAM: begin
                dout_n = lbuf[out_k];
                out_n  = out_k + 3'd1;
                if (out_k == 3'd7) begin
                    state_n = RELEASE;
                end
            end

            WRITE: begin
                if (!mwr_q) begin
                    ack_n   = 1'b1;
                    state_n = RELEASE;
                end else if (!bus.mem_wait) begin
                    mwr_n   = 1'b0;
                    ack_n   = 1'b1;
                    state_n = RELEASE;
                end
            end

            RELEASE: begin
                // Wait for the cache to drop its request so one request gets one service.
                if (!bus.sdram_req) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // Read and write commands are never presented together.
    a_cmd_excl: assert property (@(posedge clk) disable iff (!reset) !(mrd_q && mwr_q));

    // A burst marker only ever starts a stream.
    a_fill_stream: assert property (@(posedge clk) disable iff (!reset) fill_q |-> state == STREAM);

endmodule

// File: doc/cache_fill_responder.md
CACHE_FILL_RESPONDER -- requirements
Module: cache_fill_responder

Interface
REQ-001 SHALL have parameter MEMADDRBITS, default 24, meaning the word-address width of the backing memory.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port sdram_addr, input, 32 bits: byte address from the cache. Bits [3:1] are the start word; bits [MEMADDRBITS:4] are the line.
REQ-005 SHALL have port sdram_req, input, 1 bit: request, held high by the cache until serviced.
REQ-006 SHALL have port sdram_rw, input, 1 bit: 1 = line read, 0 = word write.
REQ-007 SHALL have port data_to_sdram, input, 16 bits: write data.
REQ-008 SHALL have port sdram_wr_be, input, 2 bits: write byte enables, [1] upper, [0] lower.
REQ-009 SHALL have port data_from_sdram, output, 16 bits: burst data to the cache.
REQ-010 SHALL have port sdram_fill, output, 1 bit: one-cycle marker for the first burst word.
REQ-011 SHALL have port sdram_wr_ack, output, 1 bit: one-cycle write completion pulse.
REQ-012 SHALL have ports mem_addr (output, MEMADDRBITS), mem_rd (output, 1), mem_wr (output, 1), mem_be (output, 2) and mem_wdata (output, 16): the backing-memory command.
REQ-013 SHALL have ports mem_rdata (input, 16) and mem_wait (input, 1): backing-memory read data and stall.

Function
REQ-014 SHALL implement states IDLE, FETCH, STREAM, WRITE and RELEASE; all outputs SHALL be registered.
REQ-015 In IDLE, with sdram_req=1, SHALL latch sdram_addr, data_to_sdram and sdram_wr_be, then go to FETCH if sdram_rw=1, else to WRITE.
REQ-016 A memory command SHALL be accepted on an edge where mem_rd or mem_wr is 1 and mem_wait=0; outputs SHALL hold unchanged while mem_wait=1.
REQ-017 Read data SHALL be valid on mem_rdata in the cycle after acceptance and be captured on the following edge.
REQ-018 FETCH SHALL issue 8 reads, k=0..7, at mem_addr={line, (start+k) mod 8}, reaching line offset 7 and wrapping to 0 within the line, never crossing it.
REQ-019 FETCH SHALL store each word into line-buffer slot k; a stall SHALL never drop or reorder words.
REQ-020 FETCH SHALL go to STREAM on the edge that captures slot 7.
REQ-021 STREAM SHALL drive slot 0 on data_from_sdram with sdram_fill=1 for exactly one cycle.
REQ-022 STREAM SHALL drive slots 1..7 on the next 7 consecutive cycles with sdram_fill=0, with no gaps, then go to RELEASE.
REQ-023 With mem_wait held 0, sdram_fill SHALL rise on the 9th rising edge after the accepting edge.
REQ-024 WRITE SHALL drive mem_wr=1, mem_addr=sdram_addr[MEMADDRBITS:1], mem_be=latched be and mem_wdata=latched data until accepted.
REQ-025 After write acceptance, SHALL pulse sdram_wr_ack for exactly one cycle, then go to RELEASE.
REQ-026 A write with be=2'b00 SHALL still complete and ack, and SHALL issue no mem_wr.
REQ-027 RELEASE SHALL go to IDLE only after sampling sdram_req=0, so that one request yields exactly one service.
REQ-028 data_from_sdram SHALL hold its last value outside STREAM.
REQ-029 mem_rd and mem_wr SHALL never be 1 simultaneously.
REQ-030 sdram_rw, sdram_addr and data changes while busy SHALL be ignored; the values latched in IDLE govern the whole transaction.

Reset
REQ-031 reset=0 SHALL immediately, asynchronously, force IDLE and clear all of the following to 0: data_from_sdram, sdram_fill, sdram_wr_ack, mem_addr, mem_rd, mem_wr, mem_be and mem_wdata.
REQ-032 A reset during FETCH or STREAM SHALL abandon the burst with no further fill, and SHALL accept a new request on the first edge after release if sdram_req=1.
REQ-033 The line buffer contents SHALL NOT require reset.

Verification
REQ-034 Read at sdram_addr=0x0000_0010 (line 1, start 0) with a memory where word n = n, mem_wait=0 -> fill on the 9th edge; words 0x0008..0x000F over 8 consecutive cycles.
REQ-035 Read at sdram_addr=0x0000_001A (start 5) -> mem_addr sequence 0x0D,0x0E,0x0F,0x08..0x0C; stream 0x000D,0x000E,0x000F,0x0008..0x000C.
REQ-036 Read as REQ-034 with mem_wait=1 for 3 cycles on read 2 and 1 cycle on read 6 -> fill delayed 4 cycles; stream identical and contiguous.
REQ-037 Write sdram_addr=0x0000_0046, data 0xBEEF, be=2'b01 -> one mem_wr cycle at mem_addr=0x23 with mem_be=01; one sdram_wr_ack pulse; no second write while req stays high.
REQ-038 Assert reset=0 for one cycle after the 3rd streamed word -> all outputs 0 at once, no further fill; a new read then completes normally.
REQ-039 Hold sdram_req=1 for 20 cycles after fill -> exactly one burst; the next burst occurs only after req drops and rises again.
